// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, default
// widths and the saturating grant-counter helper.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_AW  = 4;
  localparam int DEF_DW  = 4;
  localparam int STATS_W = 8;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; grant is one-hot or zero.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // NOTE: assign a default first so every path through always_comb drives
  // grant; a missing branch would otherwise infer a latch.
  always_comb begin
    grant = 2'b00;
    if (req0 && req1)
      grant = last_grant ? 2'b01 : 2'b10;
    else
      grant = {req1, req0};
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sequencer serialising two requesters onto one level-strobed RAM.
// Define RAM_ARB_STATS_EN to add saturating per-requester grant counters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          ram_wr,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] gnt_cnt0,
  output logic [STATS_W-1:0] gnt_cnt1
`endif
);

  state_t        state;
  logic          last_grant;
  logic          cmd_we;
  logic          cmd_owner;
  logic [1:0]    grant;
  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arb2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign pick = grant[1];

  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (pick) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // ram_addr/ram_wdata double as the command register: loaded on grant and
  // held through RESP so the RAM sees a stable address around the strobe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmd_we     <= 1'b0;
      cmd_owner  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      ram_wr     <= 1'b0;
      ram_rd     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            state      <= ACCESS;
            last_grant <= pick;
            cmd_owner  <= pick;
            cmd_we     <= sel_we;
            ram_addr   <= sel_addr;
            ram_wdata  <= sel_wdata;
            ram_wr     <= sel_we;
            ram_rd     <= !sel_we;
            busy       <= 1'b1;
          end
        end
        ACCESS: begin
          state  <= RESP;
          ram_wr <= 1'b0;
          ram_rd <= 1'b0;
          if (!cmd_we) begin
            if (cmd_owner) rdata1 <= ram_rdata;
            else           rdata0 <= ram_rdata;
          end
          ack0 <= !cmd_owner;
          ack1 <= cmd_owner;
        end
        RESP: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ram_wr <= 1'b0;
          ram_rd <= 1'b0;
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (state == IDLE) begin
      if (grant[0]) gnt_cnt0 <= sat_inc(gnt_cnt0);
      if (grant[1]) gnt_cnt1 <= sat_inc(gnt_cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: vector table, directed corner
// sequences and an ack-side scoreboard. Honors RAM_ARB_STATS_EN.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1;
  logic [3:0] rdata0, rdata1;
  logic       ram_wr, ram_rd, busy;
  logic [3:0] ram_addr, ram_wdata, ram_rdata;
`ifdef RAM_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(4), .DW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .ram_wr    (ram_wr),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
`ifdef RAM_ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  // Behavioural 16x4 RAM: write on clock edge while ram_wr, combinational read.
  logic [3:0] mem [16];
  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_rd ? mem[ram_addr] : 4'h0;

  typedef struct {
    bit         who;
    logic [3:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic [3:0] shadow_mem [16];
  logic [3:0] shadow_rd  [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Ack-side scoreboard and strobe exclusivity monitor.
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_excl", {31'b0, ram_wr & ram_rd}, 32'd0);
      if (ack0 | ack1) begin
        check("ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
        check("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("ack_owner", {31'b0, ack1}, {31'b0, e.who});
          check("ack_rdata", {28'b0, (e.who ? rdata1 : rdata0)}, {28'b0, e.rdata});
        end
      end
    end
  end

  task automatic push_exp(input bit who, input bit we, input logic [3:0] a,
                          input logic [3:0] d, input logic [3:0] exp_rd);
    exp_t e;
    e.who   = who;
    e.rdata = exp_rd;
    sb.push_back(e);
    if (we) shadow_mem[a] = d;
    else    shadow_rd[who] = exp_rd;
  endtask

  task automatic drive(input bit who, input bit r, input bit we,
                       input logic [3:0] a, input logic [3:0] d);
    if (who) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
    else     begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 4'h0, 4'h0);
    drive(1, 0, 0, 4'h0, 4'h0);
    sb.delete();
    shadow_rd[0] = 4'h0;
    shadow_rd[1] = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single transaction with cycle-exact strobe/ack checks; starts and ends
  // at a falling edge with the DUT idle.
  task automatic run_txn(input bit who, input bit we, input logic [3:0] a,
                         input logic [3:0] d, input logic [3:0] exp_rd);
    push_exp(who, we, a, d, exp_rd);
    drive(who, 1, we, a, d);
    @(negedge clk);
    check("acc_wr",   {31'b0, ram_wr}, {31'b0, we});
    check("acc_rd",   {31'b0, ram_rd}, {31'b0, !we});
    check("acc_addr", {28'b0, ram_addr}, {28'b0, a});
    if (we) check("acc_wdata", {28'b0, ram_wdata}, {28'b0, d});
    check("acc_noack", {30'b0, ack1, ack0}, 32'd0);
    @(negedge clk);
    check("resp_ack", {30'b0, ack1, ack0}, who ? 32'd2 : 32'd1);
    check("resp_strobes", {30'b0, ram_wr, ram_rd}, 32'd0);
    check("resp_addr_hold", {28'b0, ram_addr}, {28'b0, a});
    drive(who, 0, 0, 4'h0, 4'h0);
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    bit         who;
    bit         we;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_rdata;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int n;
    vecs[0] = '{who: 0, we: 1, addr: 4'h3, wdata: 4'hA, exp_rdata: 4'h0};
    vecs[1] = '{who: 1, we: 0, addr: 4'h3, wdata: 4'h0, exp_rdata: 4'hA};
    vecs[2] = '{who: 1, we: 1, addr: 4'h0, wdata: 4'h5, exp_rdata: 4'hA};
    vecs[3] = '{who: 0, we: 0, addr: 4'h0, wdata: 4'h0, exp_rdata: 4'h5};
    vecs[4] = '{who: 0, we: 1, addr: 4'hF, wdata: 4'hC, exp_rdata: 4'h5};
    vecs[5] = '{who: 1, we: 0, addr: 4'hF, wdata: 4'h0, exp_rdata: 4'hC};
    vecs[6] = '{who: 1, we: 1, addr: 4'h7, wdata: 4'h0, exp_rdata: 4'hC};
    vecs[7] = '{who: 0, we: 0, addr: 4'h7, wdata: 4'h0, exp_rdata: 4'h0};
    for (int i = 0; i < 16; i++) begin
      mem[i] = 4'h0;
      shadow_mem[i] = 4'h0;
    end

    do_reset();
    check("reset_state",
          {9'b0, busy, ack0, ack1, ram_wr, ram_rd, rdata0, rdata1, ram_addr, ram_wdata},
          32'd0);

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Fill every address from requester 0, read back from requester 1.
    for (int a = 0; a < 16; a++)
      run_txn(0, 1, 4'(a), 4'(a) ^ 4'hF, shadow_rd[0]);
    for (int a = 0; a < 16; a++)
      run_txn(1, 0, 4'(a), 4'h0, 4'(a) ^ 4'hF);

    // Both held high from reset: grants alternate 0,1,0,1.
    do_reset();
    push_exp(0, 1, 4'h5, 4'h1, shadow_rd[0]);
    push_exp(1, 1, 4'h6, 4'h2, shadow_rd[1]);
    push_exp(0, 1, 4'h5, 4'h1, shadow_rd[0]);
    push_exp(1, 1, 4'h6, 4'h2, shadow_rd[1]);
    drive(0, 1, 1, 4'h5, 4'h1);
    drive(1, 1, 1, 4'h6, 4'h2);
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        n++;
        if (n == 4) begin
          drive(0, 0, 0, 4'h0, 4'h0);
          drive(1, 0, 0, 4'h0, 4'h0);
        end
      end
    end
    check("hold_ack_count", n, 4);
    drive(0, 0, 0, 4'h0, 4'h0);
    drive(1, 0, 0, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("hold_idle_busy", {31'b0, busy}, 32'd0);
    check("hold_sb_empty", sb.size(), 0);

    // Asynchronous reset during the ACCESS cycle of a write.
    drive(0, 1, 1, 4'h9, 4'h3);
    @(negedge clk);
    check("pre_rst_wr", {31'b0, ram_wr}, 32'd1);
    #1 rst = 1'b1;
    #1 check("mid_rst_outputs",
             {11'b0, busy, ack0, ack1, ram_wr, ram_rd, rdata0, rdata1, ram_addr, ram_wdata},
             32'd0);
    drive(0, 0, 0, 4'h0, 4'h0);
    shadow_rd[0] = 4'h0;
    shadow_rd[1] = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_no_ack", {30'b0, ack1, ack0}, 32'd0);

    // Tie after reset: requester 0 must win first.
    push_exp(0, 0, 4'h3, 4'h0, shadow_mem[3]);
    push_exp(1, 0, 4'hF, 4'h0, shadow_mem[15]);
    drive(0, 1, 0, 4'h3, 4'h0);
    drive(1, 1, 0, 4'hF, 4'h0);
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (ack0) begin drive(0, 0, 0, 4'h0, 4'h0); n++; end
      if (ack1) begin drive(1, 0, 0, 4'h0, 4'h0); n++; end
    end
    check("tie_ack_count", n, 2);
    @(negedge clk);
    @(negedge clk);
    check("tie_sb_empty", sb.size(), 0);

`ifdef RAM_ARB_STATS_EN
    do_reset();
    check("stats_reset", {16'b0, gnt_cnt0, gnt_cnt1}, 32'd0);
    for (int i = 0; i < 300; i++)
      run_txn(0, 0, 4'h1, 4'h0, shadow_mem[1]);
    check("stats_sat0", {24'b0, gnt_cnt0}, 32'd255);
    check("stats_cnt1", {24'b0, gnt_cnt1}, 32'd0);
    run_txn(1, 0, 4'h2, 4'h0, shadow_mem[2]);
    check("stats_cnt1_inc", {24'b0, gnt_cnt1}, 32'd1);
    #1 rst = 1'b1;
    #1 check("stats_clear", {16'b0, gnt_cnt0, gnt_cnt1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    check("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
